// File: rtl/issue_pkg.sv
// Shared definitions for the integer issue queue: default widths, ALU/branch
// opcode encodings and the layout of one queue entry.
package issue_pkg;

    localparam int IQ_TAGW  = 6;
    localparam int IQ_DATAW = 32;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h2,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_NOR = 4'h6,
        OP_SLT = 4'h7,
        OP_BEQ = 4'h9
    } iq_op_e;

    typedef struct packed {
        logic                valid;
        logic [3:0]          opcode;
        logic [IQ_DATAW-1:0] rsdata;
        logic                rsvalid;
        logic [IQ_TAGW-1:0]  rstag;
        logic [IQ_DATAW-1:0] rtdata;
        logic                rtvalid;
        logic [IQ_TAGW-1:0]  rttag;
        logic [IQ_TAGW-1:0]  rdtag;
    } iq_entry_t;

endpackage

// File: rtl/iq_entry_wakeup.sv
// One operand slot's CDB snoop: a pending operand whose producer tag matches
// the broadcast captures the broadcast data and becomes valid.
module iq_entry_wakeup
    import issue_pkg::*;
#(
    parameter int TAGW  = IQ_TAGW,
    parameter int DATAW = IQ_DATAW
) (
    input  logic             vld_i,
    input  logic [TAGW-1:0]  tag_i,
    input  logic [DATAW-1:0] data_i,
    input  logic             cdb_valid_i,
    input  logic [TAGW-1:0]  cdb_tag_i,
    input  logic [DATAW-1:0] cdb_data_i,
    output logic             vld_o,
    output logic [DATAW-1:0] data_o
);

    logic hit;

    assign hit    = !vld_i && cdb_valid_i && (tag_i == cdb_tag_i);
    assign vld_o  = vld_i | hit;
    assign data_o = hit ? cdb_data_i : data_i;

endmodule

// File: rtl/issue_queue_int.sv
// Compacting, age-ordered integer issue queue. Entry 0 is always the oldest;
// the oldest entry with both operands valid is presented to the issue unit.
module issue_queue_int
    import issue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int TAGW  = IQ_TAGW,
    parameter  int DATAW = IQ_DATAW,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_en,
    input  logic [3:0]       dispatch_opcode,
    input  logic [DATAW-1:0] dispatch_rsdata,
    input  logic             dispatch_rsvalid,
    input  logic [TAGW-1:0]  dispatch_rstag,
    input  logic [DATAW-1:0] dispatch_rtdata,
    input  logic             dispatch_rtvalid,
    input  logic [TAGW-1:0]  dispatch_rttag,
    input  logic [TAGW-1:0]  dispatch_rdtag,
    input  logic             cdb_valid,
    input  logic [TAGW-1:0]  cdb_tagout,
    input  logic [DATAW-1:0] cdb_out,
    input  logic             issue_int,
    output logic             ready_int,
    output logic [3:0]       opcode,
    output logic [DATAW-1:0] rsdata,
    output logic [DATAW-1:0] rtdata,
    output logic [TAGW-1:0]  rdtag,
    output logic             iq_full,
    output logic [CW-1:0]    iq_count
);

    logic [DEPTH-1:0] valid_q, rsv_q, rtv_q;
    logic [3:0]       op_q    [DEPTH];
    logic [DATAW-1:0] rsd_q   [DEPTH];
    logic [DATAW-1:0] rtd_q   [DEPTH];
    logic [TAGW-1:0]  rstag_q [DEPTH];
    logic [TAGW-1:0]  rttag_q [DEPTH];
    logic [TAGW-1:0]  rdtag_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    logic [DEPTH-1:0] sh_v, sh_rsv, sh_rtv;
    logic [3:0]       sh_op    [DEPTH];
    logic [DATAW-1:0] sh_rsd   [DEPTH];
    logic [DATAW-1:0] sh_rtd   [DEPTH];
    logic [TAGW-1:0]  sh_rstag [DEPTH];
    logic [TAGW-1:0]  sh_rttag [DEPTH];
    logic [TAGW-1:0]  sh_rdtag [DEPTH];

    logic             rsv_d [DEPTH];
    logic             rtv_d [DEPTH];
    logic [DATAW-1:0] rsd_d [DEPTH];
    logic [DATAW-1:0] rtd_d [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [IW-1:0]    sel;
    logic             issue_acc, disp_acc;

    assign ready     = valid_q & rsv_q & rtv_q;
    assign ready_int = |ready;
    assign iq_full   = (count_q == CW'(DEPTH));
    assign iq_count  = count_q;
    assign issue_acc = ready_int && issue_int;
    assign disp_acc  = dispatch_en && !iq_full;
    assign count_d   = count_q + CW'(disp_acc) - CW'(issue_acc);

    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) sel = IW'(i);
        end
    end

    assign opcode = ready_int ? op_q[sel]    : '0;
    assign rsdata = ready_int ? rsd_q[sel]   : '0;
    assign rtdata = ready_int ? rtd_q[sel]   : '0;
    assign rdtag  = ready_int ? rdtag_q[sel] : '0;

    // Compaction first, then the new entry lands in the first free slot, so the
    // CDB snoop below sees every entry at its post-shift index.
    always_comb begin
        int src;
        int j;
        int widx;
        widx = int'(count_q) - (issue_acc ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            src = (issue_acc && i >= int'(sel)) ? i + 1 : i;
            j   = (src < DEPTH) ? src : DEPTH - 1;
            sh_v[i]     = (src < DEPTH) && valid_q[j];
            sh_op[i]    = op_q[j];
            sh_rsd[i]   = rsd_q[j];
            sh_rsv[i]   = rsv_q[j];
            sh_rstag[i] = rstag_q[j];
            sh_rtd[i]   = rtd_q[j];
            sh_rtv[i]   = rtv_q[j];
            sh_rttag[i] = rttag_q[j];
            sh_rdtag[i] = rdtag_q[j];
            if (disp_acc && i == widx) begin
                sh_v[i]     = 1'b1;
                sh_op[i]    = dispatch_opcode;
                sh_rsd[i]   = dispatch_rsdata;
                sh_rsv[i]   = dispatch_rsvalid;
                sh_rstag[i] = dispatch_rstag;
                sh_rtd[i]   = dispatch_rtdata;
                sh_rtv[i]   = dispatch_rtvalid;
                sh_rttag[i] = dispatch_rttag;
                sh_rdtag[i] = dispatch_rdtag;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_entry_wakeup #(.TAGW(TAGW), .DATAW(DATAW)) u_rs (
            .vld_i       (sh_rsv[g]),
            .tag_i       (sh_rstag[g]),
            .data_i      (sh_rsd[g]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tagout),
            .cdb_data_i  (cdb_out),
            .vld_o       (rsv_d[g]),
            .data_o      (rsd_d[g])
        );
        iq_entry_wakeup #(.TAGW(TAGW), .DATAW(DATAW)) u_rt (
            .vld_i       (sh_rtv[g]),
            .tag_i       (sh_rttag[g]),
            .data_i      (sh_rtd[g]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tagout),
            .cdb_data_i  (cdb_out),
            .vld_o       (rtv_d[g]),
            .data_o      (rtd_d[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= sh_v;
            count_q <= count_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            op_q[i]    <= sh_op[i];
            rsd_q[i]   <= rsd_d[i];
            rsv_q[i]   <= rsv_d[i];
            rstag_q[i] <= sh_rstag[i];
            rtd_q[i]   <= rtd_d[i];
            rtv_q[i]   <= rtv_d[i];
            rttag_q[i] <= sh_rttag[i];
            rdtag_q[i] <= sh_rdtag[i];
        end
    end

endmodule

// File: tb/tb_issue_queue_int.sv
// Scoreboard bench for issue_queue_int: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_issue_queue_int;
    import issue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata, dispatch_rtdata;
    logic        dispatch_rsvalid, dispatch_rtvalid;
    logic [5:0]  dispatch_rstag, dispatch_rttag, dispatch_rdtag;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        issue_int;
    logic        ready_int;
    logic [3:0]  opcode;
    logic [31:0] rsdata, rtdata;
    logic [5:0]  rdtag;
    logic        iq_full;
    logic [2:0]  iq_count;

    issue_queue_int #(.DEPTH(DEPTH), .TAGW(6), .DATAW(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .dispatch_en(dispatch_en),
        .dispatch_opcode(dispatch_opcode), .dispatch_rsdata(dispatch_rsdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rstag(dispatch_rstag),
        .dispatch_rtdata(dispatch_rtdata), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rttag(dispatch_rttag), .dispatch_rdtag(dispatch_rdtag),
        .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .issue_int(issue_int), .ready_int(ready_int), .opcode(opcode),
        .rsdata(rsdata), .rtdata(rtdata), .rdtag(rdtag),
        .iq_full(iq_full), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  rd;
        logic        full;
        logic [2:0]  cnt;
    } exp_t;

    iq_entry_t mq[$];
    exp_t      sc_q[$];
    int        n_chk = 0;
    int        n_fail = 0;
    logic [3:0] ops [7] = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9};

    function automatic int first_ready();
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].rsvalid && mq[k].rtvalid) return k;
        return -1;
    endfunction

    task automatic model_update();
        int idx;
        bit disp;
        iq_entry_t e;
        if (!reset || flush) begin
            mq.delete();
            return;
        end
        idx  = first_ready();
        disp = dispatch_en && (mq.size() < DEPTH);
        if (issue_int && idx >= 0) mq.delete(idx);
        foreach (mq[k]) begin
            if (cdb_valid && !mq[k].rsvalid && mq[k].rstag == cdb_tagout) begin
                mq[k].rsvalid = 1'b1;
                mq[k].rsdata  = cdb_out;
            end
            if (cdb_valid && !mq[k].rtvalid && mq[k].rttag == cdb_tagout) begin
                mq[k].rtvalid = 1'b1;
                mq[k].rtdata  = cdb_out;
            end
        end
        if (disp) begin
            e = '{valid: 1'b1, opcode: dispatch_opcode, rsdata: dispatch_rsdata,
                  rsvalid: dispatch_rsvalid, rstag: dispatch_rstag,
                  rtdata: dispatch_rtdata, rtvalid: dispatch_rtvalid,
                  rttag: dispatch_rttag, rdtag: dispatch_rdtag};
            if (cdb_valid && !e.rsvalid && e.rstag == cdb_tagout) begin
                e.rsvalid = 1'b1;
                e.rsdata  = cdb_out;
            end
            if (cdb_valid && !e.rtvalid && e.rttag == cdb_tagout) begin
                e.rtvalid = 1'b1;
                e.rtdata  = cdb_out;
            end
            mq.push_back(e);
        end
    endtask

    task automatic push_expected();
        exp_t x;
        int idx;
        idx     = first_ready();
        x.ready = (idx >= 0);
        x.op    = (idx >= 0) ? mq[idx].opcode : 4'h0;
        x.rs    = (idx >= 0) ? mq[idx].rsdata : 32'h0;
        x.rt    = (idx >= 0) ? mq[idx].rtdata : 32'h0;
        x.rd    = (idx >= 0) ? mq[idx].rdtag  : 6'h0;
        x.full  = (mq.size() == DEPTH);
        x.cnt   = 3'(mq.size());
        sc_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        push_expected();
    endtask

    task automatic idle();
        flush = 0; dispatch_en = 0; dispatch_opcode = 0;
        dispatch_rsdata = 0; dispatch_rsvalid = 0; dispatch_rstag = 0;
        dispatch_rtdata = 0; dispatch_rtvalid = 0; dispatch_rttag = 0;
        dispatch_rdtag = 0; cdb_valid = 0; cdb_tagout = 0; cdb_out = 0;
        issue_int = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rsd, input logic rsv,
                        input logic [5:0] rst, input logic [31:0] rtd, input logic rtv,
                        input logic [5:0] rtt, input logic [5:0] rdt);
        dispatch_en = 1; dispatch_opcode = op;
        dispatch_rsdata = rsd; dispatch_rsvalid = rsv; dispatch_rstag = rst;
        dispatch_rtdata = rtd; dispatch_rtvalid = rtv; dispatch_rttag = rtt;
        dispatch_rdtag = rdt;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tagout = t; cdb_out = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sc_q.size() > 0) begin
                e = sc_q.pop_front();
                chk("ready_int", 32'(ready_int), 32'(e.ready));
                chk("opcode",    32'(opcode),    32'(e.op));
                chk("rsdata",    rsdata,         e.rs);
                chk("rtdata",    rtdata,         e.rt);
                chk("rdtag",     32'(rdtag),     32'(e.rd));
                chk("iq_full",   32'(iq_full),   32'(e.full));
                chk("iq_count",  32'(iq_count),  32'(e.cnt));
            end
        end
    end

    initial begin : driver
        idle();
        reset = 0;
        issue_int = 1;
        tick();
        tick();
        reset = 1;
        tick();
        issue_int = 0;
        tick();

        disp(OP_ADD, 32'hA, 1, 6'h00, 32'h5, 1, 6'h00, 6'h0E);
        tick();
        idle(); issue_int = 1;
        tick();
        idle();
        tick();

        disp(OP_SUB, 32'h0, 0, 6'h0B, 32'h5, 1, 6'h00, 6'h01);
        tick();
        idle(); cdb(6'h0B, 32'hF);
        tick();
        idle();
        tick();
        issue_int = 1;
        tick();
        idle();
        disp(OP_SUB, 32'h0, 0, 6'h0B, 32'h5, 1, 6'h00, 6'h02);
        cdb(6'h0B, 32'hF);
        tick();
        idle(); issue_int = 1;
        tick();
        idle();

        disp(OP_AND, 32'h0, 0, 6'h03, 32'h7, 1, 6'h00, 6'h21);
        tick();
        idle(); disp(OP_OR, 32'h11, 1, 6'h00, 32'h22, 1, 6'h00, 6'h22);
        tick();
        idle(); cdb(6'h03, 32'h33); issue_int = 1;
        tick();
        idle(); issue_int = 1;
        tick();
        idle();
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            disp(ops[i], 32'(i + 1), 1, 6'h00, 32'(i + 16), 1, 6'h00, 6'(i + 8));
            tick();
        end
        disp(OP_BEQ, 32'hDEAD, 1, 6'h00, 32'hBEEF, 1, 6'h00, 6'h3F);
        issue_int = 1;
        tick();
        idle();
        tick();

        disp(OP_NOR, 32'h1, 1, 6'h00, 32'h2, 1, 6'h00, 6'h05);
        flush = 1; issue_int = 1;
        tick();
        idle();
        tick();

        for (int i = 0; i < 3; i++) begin
            disp(OP_SLT, 32'(i), 1, 6'h00, 32'(i), 0, 6'h07, 6'(i));
            tick();
        end
        idle();
        #2;
        reset = 0;
        mq.delete();
        sc_q.delete(sc_q.size() - 1);
        push_expected();
        tick();
        reset = 1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            idle();
            flush       = ($urandom_range(0, 39) == 0);
            issue_int   = $urandom_range(0, 1) == 1;
            cdb_valid   = $urandom_range(0, 1) == 1;
            cdb_tagout  = 6'($urandom_range(0, 7));
            cdb_out     = $urandom;
            if ($urandom_range(0, 2) != 0)
                disp(ops[$urandom_range(0, 6)], $urandom, $urandom_range(0, 1) == 1,
                     6'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) == 1,
                     6'($urandom_range(0, 7)), 6'($urandom));
            tick();
        end
        idle();
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue_int.md
Name: issue_queue_int

Overview:
- Integer issue queue directly upstream of the issue unit.
- Buffers dispatched integer/branch instructions until both source operands are valid, snooping the CDB to wake pending operands.
- Presents the oldest ready entry to the issue unit (opcode, rsdata, rtdata, rdtag with ready_int) and retires it when issue_int grants.
- Compacting, age-ordered queue: entry 0 is always the oldest.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAGW, 6, physical register tag width.
- DATAW, 32, operand width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  synchronous clear of all entries (branch mispredict).
- dispatch_en  in  1  write a new entry this cycle.
- dispatch_opcode  in  4  ALU/branch opcode.
- dispatch_rsdata  in  DATAW  rs value (meaningful when rsvalid=1).
- dispatch_rsvalid  in  1  rs value already available.
- dispatch_rstag  in  TAGW  producer tag of rs when rsvalid=0.
- dispatch_rtdata, dispatch_rtvalid, dispatch_rttag  in  DATAW/1/TAGW  same for rt.
- dispatch_rdtag  in  TAGW  destination tag.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tagout  in  TAGW  CDB broadcast tag.
- cdb_out  in  DATAW  CDB broadcast data.
- issue_int  in  1  grant from issue unit; consumes the presented entry.
- ready_int  out  1  an entry is ready for issue.
- opcode  out  4  opcode of the selected entry.
- rsdata, rtdata  out  DATAW  operands of the selected entry.
- rdtag  out  TAGW  destination tag of the selected entry.
- iq_full  out  1  count == DEPTH.
- iq_count  out  clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset (reset=0, async): all entry valid bits 0, count 0. ready_int=0, opcode/rsdata/rtdata/rdtag=0, iq_full=0, iq_count=0.
- Entry fields: valid, opcode, rsdata, rsvalid, rstag, rtdata, rtvalid, rttag, rdtag.
- Ready condition (per entry, from registered state): valid & rsvalid & rtvalid.
- Select: lowest-index ready entry (oldest-first). ready_int and data outputs are combinational from registered state.
- Outputs are 0 when ready_int=0.
- Issue handshake:
  - issue_int is honoured only when ready_int=1; otherwise it is ignored.
  - On a clock edge with ready_int & issue_int, the selected entry is removed.
  - Entries above the removed entry shift down one index; age order is preserved.
- Dispatch:
  - Ignored when iq_full=1, including when issue_int occurs in the same cycle; the upstream stage must stall on iq_full.
  - Otherwise written at index count (or count-1 if an issue occurs the same cycle), after compaction.
- CDB wakeup:
  - Each cycle, every valid entry with rsvalid=0 and rstag==cdb_tagout (cdb_valid=1) captures cdb_out into rsdata and sets rsvalid. rt is handled identically.
  - An entry woken at edge N is ready from cycle N+1 (one-cycle wakeup latency).
- Dispatch/CDB race: if the dispatched operand is not valid and its tag matches the same-cycle CDB broadcast, the entry is written with the CDB data and valid=1. No broadcast is lost.
- Simultaneous issue + wakeup on a shifting entry: the wakeup applies to the entry at its new index.
- Count:
  - Next count = count + dispatch_accepted - issue_accepted.
  - iq_full and iq_count are registered-state derived.
  - Count never exceeds DEPTH and never underflows.
- Flush: synchronous, highest priority. It clears all valid bits and count on the edge; same-cycle dispatch and issue are discarded.
- Reset asserted mid-operation: immediate clear as above. Operation resumes the cycle after reset=1.

Decomposition:
- Shared package (issue_pkg): TAGW/DATAW constants, opcode encodings (ADD=4'h0, SUB=4'h2, AND=4'h4, OR=4'h5, NOR=4'h6, SLT=4'h7, BEQ=4'h9), and the queue-entry field layout.
- One natural sub-module, iq_entry_wakeup: per-operand tag compare and capture, instantiated twice per entry.

Test Plan:
- Reset/empty: reset=0 then 1, issue_int=1 -> ready_int=0, iq_count=0, all outputs 0.
- Ready dispatch: ADD with rsdata=0xA, rtdata=0x5 (both valid), rdtag=0x0E -> next cycle ready_int=1, outputs 0x0/0xA/0x5/0x0E. Grant with issue_int -> iq_count returns to 0.
- CDB wakeup: dispatch SUB with rs waiting on tag 0x0B and rt=0x5 valid; broadcast cdb_tagout=0x0B, cdb_out=0xF -> ready_int=1 one cycle later, rsdata=0xF. Same-cycle dispatch/broadcast race also yields rsdata=0xF.
- Age order: dispatch A (rs waiting on tag 0x03), then B (ready); wake A -> B issues first, then A. Verify A shifts to index 0 with correct data.
- Full: fill DEPTH=4 entries -> iq_full=1. Dispatch with simultaneous issue_int -> dispatch dropped, iq_count=3.
- Flush/reset mid-op: with 3 entries queued, assert flush with dispatch_en=1 -> iq_count=0, ready_int=0 next cycle. Repeat using async reset pulse between edges -> immediate clear.
